// File: rtl/pong_pkg.sv
// Shared definitions for the ping-pong game blocks.
// Holds the ball-engine state enum, the default screen and geometry
// constants, and the helper that derives the serve (centre) position.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    PLAY   = 2'd1,
    MISSED = 2'd2
  } state_e;

  localparam int H_RES_DEF        = 640;
  localparam int V_RES_DEF        = 480;
  localparam int BALL_SIZE_DEF    = 8;
  localparam int PADDLE_X_DEF     = 620;
  localparam int PADDLE_H_DEF     = 64;
  localparam int SPEED_DEF        = 4;
  localparam int SERVE_FRAMES_DEF = 60;

  // Top-left coordinate that puts a square ball in the middle of an axis.
  function automatic int centre(input int res, input int size);
    return (res - size) / 2;
  endfunction

  localparam int CX_DEF = centre(H_RES_DEF, BALL_SIZE_DEF);  // 316
  localparam int CY_DEF = centre(V_RES_DEF, BALL_SIZE_DEF);  // 236

endpackage

// File: rtl/ball_axis.sv
// One axis of ball motion (used for both X and Y).
// Ports:
//   pos_i   : current top/left coordinate (unsigned)
//   dir_i   : current signed step per frame
//   lo_i    : smallest legal coordinate
//   hi_i    : largest legal coordinate
//   pos_o   : next coordinate, clamped to [lo_i, hi_i]
//   dir_o   : next step, reflected when a bound is crossed
//   under_o : raw next coordinate fell below lo_i
//   over_o  : raw next coordinate rose above hi_i
module ball_axis
  import pong_pkg::*;
#(
  parameter int SPEED = SPEED_DEF
) (
  input  logic        [9:0]  pos_i,
  input  logic signed [10:0] dir_i,
  input  logic signed [10:0] lo_i,
  input  logic signed [10:0] hi_i,
  output logic signed [10:0] pos_o,
  output logic signed [10:0] dir_o,
  output logic               under_o,
  output logic               over_o
);

  localparam logic signed [10:0] SPD = 11'(SPEED);

  logic signed [10:0] sum;

  // NOTE: every output gets a default before the if-chain, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    sum     = $signed({1'b0, pos_i}) + dir_i;
    under_o = (sum < lo_i);
    over_o  = (sum > hi_i);
    pos_o   = sum;
    dir_o   = dir_i;
    if (under_o) begin
      pos_o = lo_i;
      dir_o = SPD;
    end else if (over_o) begin
      pos_o = hi_i;
      dir_o = -SPD;
    end
  end

endmodule

// File: rtl/ball_controller.sv
// Ball-motion engine: advances the ball once per frame, bounces it off the
// top, bottom and left walls and the right-hand paddle, pulses `hit` on a
// paddle bounce and `miss` when the ball gets past, then re-serves from
// centre after SERVE_FRAMES frames.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   frame_tick  : one-cycle pulse per frame
//   enable      : 0 freezes motion and the serve timer
//   paddle_y    : paddle top y, sampled on frame_tick
//   ball_x/y    : registered ball top-left position
//   hit, miss   : registered one-cycle event pulses
module ball_controller
  import pong_pkg::*;
#(
  parameter int H_RES        = H_RES_DEF,
  parameter int V_RES        = V_RES_DEF,
  parameter int BALL_SIZE    = BALL_SIZE_DEF,
  parameter int PADDLE_X     = PADDLE_X_DEF,
  parameter int PADDLE_H     = PADDLE_H_DEF,
  parameter int SPEED        = SPEED_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [9:0] paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       hit,
  output logic       miss
);

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic        [9:0]  CX    = 10'(centre(H_RES, BALL_SIZE));
  localparam logic        [9:0]  CY    = 10'(centre(V_RES, BALL_SIZE));
  localparam logic signed [10:0] SPD   = 11'(SPEED);
  localparam logic signed [10:0] X_MAX = 11'(H_RES - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX = 11'(V_RES - BALL_SIZE);
  localparam logic signed [11:0] BS12  = 12'(BALL_SIZE);
  localparam logic signed [11:0] PX12  = 12'(PADDLE_X);
  localparam logic signed [11:0] PH12  = 12'(PADDLE_H);

  state_e             state_q;
  logic        [9:0]  x_q, y_q;
  logic signed [10:0] dx_q, dy_q;
  logic        [CW-1:0] cnt_q;
  logic               par_q, hit_q, miss_q;

  logic signed [10:0] ax_pos, ax_dir, ay_pos, ay_dir;
  logic               ax_under, ax_over, ay_under, ay_over;

  ball_axis #(.SPEED(SPEED)) u_axis_x (
    .pos_i(x_q), .dir_i(dx_q), .lo_i(11'sd0), .hi_i(X_MAX),
    .pos_o(ax_pos), .dir_o(ax_dir), .under_o(ax_under), .over_o(ax_over)
  );

  ball_axis #(.SPEED(SPEED)) u_axis_y (
    .pos_i(y_q), .dir_i(dy_q), .lo_i(11'sd0), .hi_i(Y_MAX),
    .pos_o(ay_pos), .dir_o(ay_dir), .under_o(ay_under), .over_o(ay_over)
  );

  // Paddle test runs in 12 bits so paddle_y + PADDLE_H cannot overflow.
  // The X axis clamps at H_RES-BALL_SIZE, but a ball still left of the
  // paddle face can never reach that clamp, so its position is exact here.
  logic signed [11:0] bx12, nx12, ny12, py12;
  logic               paddle_hit, miss_now;
  logic signed [10:0] nx_d, dx_d;

  always_comb begin
    bx12       = $signed({2'b00, x_q});
    nx12       = {ax_pos[10], ax_pos};
    ny12       = {ay_pos[10], ay_pos};
    py12       = $signed({2'b00, paddle_y});
    paddle_hit = (dx_q > 11'sd0) &&
                 (bx12 + BS12 <= PX12) && (nx12 + BS12 > PX12) &&
                 (ny12 + BS12 > py12) && (ny12 < py12 + PH12);
    miss_now   = !paddle_hit && ax_over;
    nx_d       = paddle_hit ? 11'(PADDLE_X - BALL_SIZE) : ax_pos;
    dx_d       = paddle_hit ? -SPD : ax_dir;
  end

  wire tick_en = frame_tick && enable;

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SERVE;
      x_q     <= CX;
      y_q     <= CY;
      dx_q    <= -SPD;
      dy_q    <= SPD;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        SERVE: begin
          if (tick_en) begin
            cnt_q <= cnt_q + 1'b1;
            // Tick that reaches SERVE_FRAMES starts play without moving.
            if (cnt_q == CW'(SERVE_FRAMES - 1)) state_q <= PLAY;
          end
        end
        PLAY: begin
          if (tick_en) begin
            if (miss_now) begin
              miss_q  <= 1'b1;
              state_q <= MISSED;
            end else begin
              x_q   <= nx_d[9:0];
              y_q   <= ay_pos[9:0];
              dx_q  <= dx_d;
              dy_q  <= ay_dir;
              hit_q <= paddle_hit;
            end
          end
        end
        MISSED: begin
          // Completes even when disabled; vertical serve direction alternates.
          x_q     <= CX;
          y_q     <= CY;
          cnt_q   <= '0;
          dx_q    <= -SPD;
          dy_q    <= par_q ? SPD : -SPD;
          par_q   <= ~par_q;
          state_q <= SERVE;
        end
        default: state_q <= SERVE;
      endcase
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign hit    = hit_q;
  assign miss   = miss_q;

endmodule

// File: tb/tb_ball_controller.sv
// Self-checking bench for ball_controller: a frame-level game model runs
// alongside the DUT and a negedge process compares all outputs every cycle;
// directed phases add literal checks for serve timing, walls, paddle hit,
// misses, freeze and reset precedence.
module tb_ball_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b1;
  logic [9:0] paddle_y = '0;
  logic [9:0] ball_x, ball_y;
  logic       hit, miss;

  ball_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .paddle_y(paddle_y), .ball_x(ball_x), .ball_y(ball_y), .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Game model: mode 0 = waiting at centre, 1 = in play, 2 = ball just lost.
  int m_x, m_y, m_dx, m_dy, m_cnt, m_par, m_mode, m_hit, m_miss;
  int pmode = 0;  // 0: paddle follows ball, 1: paddle kept away

  function automatic int pick_py();
    if (pmode == 0) return (m_y >= 20) ? m_y - 20 : 0;
    return (m_y < 240) ? 400 : 0;
  endfunction

  function automatic bit paddle_catches(int nx, int ny, int py);
    return (m_dx > 0) && (m_x + 8 <= 620) && (nx + 8 > 620) &&
           (ny + 8 > py) && (ny < py + 64);
  endfunction

  function automatic bit would_miss(int py);
    int nx, ny;
    if (m_mode != 1) return 1'b0;
    nx = m_x + m_dx;
    ny = m_y + m_dy;
    if (ny < 0) ny = 0;
    if (ny > 472) ny = 472;
    return !paddle_catches(nx, ny, py) && (nx > 632);
  endfunction

  task automatic model_edge(input bit tick, input bit en, input bit rst, input int py);
    int nx, ny, ndx, ndy;
    if (rst) begin
      m_x = 316; m_y = 236; m_dx = -4; m_dy = 4;
      m_cnt = 0; m_par = 0; m_mode = 0; m_hit = 0; m_miss = 0;
      return;
    end
    m_hit = 0;
    m_miss = 0;
    if (m_mode == 2) begin
      m_x = 316; m_y = 236; m_cnt = 0; m_dx = -4;
      m_dy = (m_par == 0) ? -4 : 4;
      m_par = 1 - m_par;
      m_mode = 0;
    end else if (tick && en) begin
      if (m_mode == 0) begin
        m_cnt++;
        if (m_cnt == 60) m_mode = 1;
      end else begin
        nx = m_x + m_dx; ny = m_y + m_dy; ndx = m_dx; ndy = m_dy;
        if (ny < 0) begin ny = 0; ndy = 4; end
        else if (ny > 472) begin ny = 472; ndy = -4; end
        if (nx < 0) begin nx = 0; ndx = 4; end
        if (paddle_catches(nx, ny, py)) begin
          nx = 612; ndx = -4; m_hit = 1;
        end else if (nx > 632) begin
          m_miss = 1; m_mode = 2;
          return;
        end
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
      end
    end
  endtask

  // One clock: drive at negedge, advance the model at the posedge.
  task automatic step(input bit tick, input bit en, input bit rst);
    int py;
    @(negedge clk);
    py = pick_py();
    frame_tick = tick; enable = en; reset = rst; paddle_y = 10'(py);
    @(posedge clk);
    model_edge(tick, en, rst, py);
    #1;
  endtask

  task automatic frame(input bit en);
    step(1'b1, en, 1'b0);
    step(1'b0, 1'b1, 1'b0);
  endtask

  // Per-cycle comparison plus observed-event bookkeeping.
  bit chk_en = 1'b0;
  bit seen_left = 1'b0, seen_top = 1'b0, seen_bottom = 1'b0;
  int dut_misses = 0;
  int lives = 3;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ball_x", int'(ball_x), m_x);
      check("ball_y", int'(ball_y), m_y);
      check("hit", int'(hit), m_hit);
      check("miss", int'(miss), m_miss);
      if (ball_x == 10'd0) seen_left = 1'b1;
      if (ball_y == 10'd0) seen_top = 1'b1;
      if (ball_y == 10'd472) seen_bottom = 1'b1;
      if (miss === 1'b1) begin
        dut_misses++;
        lives = (lives == 1) ? 3 : lives - 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int sx, sy;

    // Reset and serve timing.
    model_edge(1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    check("reset_x", int'(ball_x), 316);
    check("reset_y", int'(ball_y), 236);
    check("reset_hit", int'(hit), 0);
    check("reset_miss", int'(miss), 0);
    repeat (60) frame(1'b1);
    check("serve60_x", int'(ball_x), 316);
    check("serve60_y", int'(ball_y), 236);
    frame(1'b1);
    check("first_move_x", int'(ball_x), 312);
    check("first_move_y", int'(ball_y), 240);

    // Play with the paddle tracking until a paddle bounce.
    pmode = 0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (m_hit == 1) begin
        got = 1'b1;
        check("hit_pulse", int'(hit), 1);
        check("hit_x", int'(ball_x), 612);
      end
      step(1'b0, 1'b1, 1'b0);
      if (got) check("hit_one_cycle", int'(hit), 0);
    end
    check("hit_reached", int'(got), 1);
    frame(1'b1);
    check("after_hit_x", int'(ball_x), 608);
    check("left_wall_seen", int'(seen_left), 1);
    check("bottom_wall_seen", int'(seen_bottom), 1);
    check("top_wall_seen", int'(seen_top), 1);

    // Freeze in play.
    sx = m_x; sy = m_y;
    repeat (10) frame(1'b0);
    check("freeze_x", int'(ball_x), sx);
    check("freeze_y", int'(ball_y), sy);

    // Three misses with the paddle kept away.
    pmode = 1;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int i = 0; i < 600 && !got; i++) begin
        step(1'b1, 1'b1, 1'b0);
        if (m_miss == 1) begin
          got = 1'b1;
          check("miss_pulse", int'(miss), 1);
        end
        step(1'b0, 1'b1, 1'b0);
      end
      check("miss_reached", int'(got), 1);
      check("reserve_x", int'(ball_x), 316);
      check("reserve_y", int'(ball_y), 236);
      if (k == 0) begin
        check("lives_after_one", lives, 2);
        repeat (30) frame(1'b1);
        repeat (10) frame(1'b0);
        repeat (30) frame(1'b1);
      end else begin
        repeat (60) frame(1'b1);
      end
      check("serve_hold_x", int'(ball_x), 316);
      frame(1'b1);
      check("serve_dir_y", int'(ball_y), (k % 2 == 0) ? 232 : 240);
    end
    check("miss_count", dut_misses, 3);
    check("lives_wrapped", lives, 3);

    // Reset on the very tick that would lose the ball.
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      if (would_miss(pick_py())) begin
        got = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        check("rst_miss_blocked", int'(miss), 0);
        check("rst_x", int'(ball_x), 316);
        check("rst_y", int'(ball_y), 236);
      end else begin
        frame(1'b1);
      end
    end
    check("rst_case_reached", int'(got), 1);
    repeat (60) frame(1'b1);
    check("rst_serve_x", int'(ball_x), 316);
    frame(1'b1);
    check("rst_restart_x", int'(ball_x), 312);
    check("rst_restart_y", int'(ball_y), 240);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_controller.md
# ball_controller

Ball-motion engine for the ping-pong game. It advances the ball once per video frame, reflects it off the top, bottom and left walls and off the player paddle on the right, and emits a one-cycle `miss` pulse when the ball passes the paddle. That pulse drives `life_counter`'s `miss` input. After a miss, the block re-serves the ball from screen centre following a fixed frame delay.

## Interface
Parameters:
- `H_RES`, 640: active width in pixels
- `V_RES`, 480: active height in pixels
- `BALL_SIZE`, 8: square ball edge in pixels
- `PADDLE_X`, 620: x of the paddle's left (hitting) face
- `PADDLE_H`, 64: paddle height in pixels
- `SPEED`, 4: pixels per frame on each axis
- `SERVE_FRAMES`, 60: frames the ball waits at centre before play

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `frame_tick` in 1: one-cycle pulse per frame (vsync start)
- `enable` in 1: 0 freezes all motion and timers
- `paddle_y` in 10: paddle top y, held stable across `frame_tick`
- `ball_x` out 10: ball left x
- `ball_y` out 10: ball top y
- `hit` out 1: one-cycle pulse on paddle bounce
- `miss` out 1: one-cycle pulse on ball lost

## Operation
- Centre position: `CX = (H_RES-BALL_SIZE)/2` (316), `CY = (V_RES-BALL_SIZE)/2` (236).
- Reset values:
  - `ball_x=CX`, `ball_y=CY`, `hit=0`, `miss=0`.
  - State SERVE, serve counter 0.
  - `dx=-SPEED`, `dy=+SPEED`, serve-parity 0.
- States:
  - **SERVE**: ball held at centre. Each `frame_tick` increments the counter. On the tick that brings the counter to `SERVE_FRAMES`, go to PLAY with no motion on that tick.
  - **PLAY**: each `frame_tick` computes the next position, applies reflections, and may go to MISSED.
  - **MISSED**: lasts exactly one clock. Load centre, clear the counter, set `dx=-SPEED`, set `dy=±SPEED` alternating by serve-parity, toggle parity, go to SERVE.
- Arithmetic: next position is `nx = ball_x + dx`, `ny = ball_y + dy`, computed in 11-bit signed.
- Y axis:
  - If `ny < 0`: set `ny=0`, `dy=+SPEED`.
  - If `ny > V_RES-BALL_SIZE`: set `ny=V_RES-BALL_SIZE`, `dy=-SPEED`.
- X axis, left wall: if `nx < 0`, set `nx=0`, `dx=+SPEED`.
- X axis, paddle: applies when `dx>0`, `ball_x+BALL_SIZE <= PADDLE_X`, `nx+BALL_SIZE > PADDLE_X`, and `ny+BALL_SIZE > paddle_y` and `ny < paddle_y+PADDLE_H` (overlap uses the reflected `ny`). Then set `nx=PADDLE_X-BALL_SIZE`, `dx=-SPEED`, pulse `hit`.
- X axis, miss: if the paddle rule did not fire and `nx > H_RES-BALL_SIZE`, pulse `miss`, go to MISSED, and do not update the position.
- Axes reflect independently. A corner hit flips both `dx` and `dy` in the same tick.
- `enable=0`: ticks are ignored in every state and outputs hold. The MISSED→SERVE transition still completes.

## Timing
- All outputs are registered. Position, `hit` and `miss` update on the clock edge after the cycle in which `frame_tick=1`.
- `hit` and `miss` are high for exactly one clock and are never high together.
- `miss` is followed by at least `SERVE_FRAMES` frames with no further `miss`. The `life_counter` edge detector therefore sees one rising edge per lost ball.
- `reset` overrides everything on the same edge, including a tick that would have produced a miss: `miss` stays 0 and the block returns to SERVE at centre.
- `paddle_y` is sampled only in the `frame_tick` cycle.

## Structure
- Package `pong_pkg` holds:
  - the state enum: SERVE, PLAY, MISSED
  - the default resolution and geometry constants
  - the `CX`/`CY` derivation
- One sub-module, `ball_axis`, is instantiated for X and Y. It takes position, direction, lower bound and upper bound, and returns the reflected next position, the next direction, and over/under flags. Paddle and miss logic stay in the top level.
- The serve timer is a counter inside the top level.

## Test plan
- **Serve timing:** reset, then 60 ticks → ball stays at (316,236). Tick 61 → (312,240), `miss=0`, `hit=0`.
- **Top wall:** PLAY with ball at y=2, `dy=-4`, tick → `ball_y=0`, `dy=+4`. Next tick → y=4.
- **Paddle hit:** `paddle_y=200`, ball at (610,220), `dx=+4`, tick → `ball_x=612`, `hit` high one cycle, next tick → x=608, `miss` never asserted.
- **Miss:** `paddle_y=0`, ball at (630,400), `dx=+4`, tick → `miss` high one cycle, then ball at (316,236) in SERVE with `dy=-4`. An attached `life_counter` goes 3→2, and after three such misses it wraps to 3.
- **Freeze:** `enable=0` for 10 ticks in PLAY → `ball_x`/`ball_y` unchanged, serve counter unchanged in SERVE.
- **Reset precedence:** assert `reset` in the same cycle as the miss-causing tick → `miss` stays 0, ball at centre, SERVE counter 0.
